draw_strings: RTL and testbench

- Text overlay renderer feeding the top-level VGA colour mux alongside draw_field.
- Takes the current pixel coordinate from the VGA timing generator and game statistics from game logic.
- Outputs a registered 24-bit colour plus enable for "SCORE nnnnnn", "LINES nnnnnn", "LEVEL nnnnnn" and, in the game-over state, a "GAME OVER" banner.
- Latency of 1 clk matches the draw_field timing, so the top's sync delay line applies unchanged.

---
 rtl/draw_strings.sv | 271 +++++++++++++++++++++++++++
 tb/tb_draw_strings.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/draw_strings.sv
// -----------------------------------------------------------------------------
// draw_strings
//   Text overlay renderer for the VGA colour mux. Draws three statistics lines
//   ("SCORE nnnnnn", "LINES nnnnnn", "LEVEL nnnnnn") and, while the game is
//   over, a "GAME OVER" banner. Each 8x8 glyph is magnified by 2**SCALE_LOG2.
//   Statistics are sampled once per frame, at frame start, so a frame never
//   shows a mix of old and new values. Output latency is one clock, the same
//   as draw_field.
//
//   Optional feature macro: DRAW_STRINGS_GO_BLINK_EN
//     defined   : banner shown only while frame_cnt[BLINK_BIT] == 0
//     undefined : banner shown steadily while game over
//
// Ports
//   clk                 in   pixel clock
//   reset_n             in   asynchronous active-low reset
//   pix_x_i, pix_y_i    in   current pixel coordinate (PIX_WIDTH bits)
//   gd_score            in   6 BCD digits, [23:20] most significant
//   gd_lines            in   6 BCD digits
//   gd_level            in   6 BCD digits
//   gd_game_over_state  in   game-over flag
//   vga_data_o          out  {R,G,B} of the text pixel, 0 when not set
//   vga_data_en_o       out  1 when a text pixel is set at this coordinate
// -----------------------------------------------------------------------------
module draw_strings #(
    parameter int          PIX_WIDTH  = 12,
    parameter int          SCALE_LOG2 = 2,
    parameter int          STAT_X0    = 800,
    parameter int          SCORE_Y0   = 200,
    parameter int          LINES_Y0   = 264,
    parameter int          LEVEL_Y0   = 328,
    parameter int          GO_X0      = 496,
    parameter int          GO_Y0      = 480,
    parameter logic [23:0] TEXT_COLOR = 24'hFFFFFF,
    parameter logic [23:0] GO_COLOR   = 24'hFF0000,
    parameter int          BLINK_BIT  = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [PIX_WIDTH-1:0] pix_x_i,
    input  logic [PIX_WIDTH-1:0] pix_y_i,
    input  logic [23:0]          gd_score,
    input  logic [23:0]          gd_lines,
    input  logic [23:0]          gd_level,
    input  logic                 gd_game_over_state,
    output logic [23:0]          vga_data_o,
    output logic                 vga_data_en_o
);

    localparam int CHAR_PX = 8 << SCALE_LOG2;

    // Rectangle bounds: inclusive low edge, exclusive high edge.
    localparam logic [PIX_WIDTH-1:0] STAT_X_LO  = PIX_WIDTH'(STAT_X0);
    localparam logic [PIX_WIDTH-1:0] STAT_X_HI  = PIX_WIDTH'(STAT_X0 + 12 * CHAR_PX);
    localparam logic [PIX_WIDTH-1:0] SCORE_Y_LO = PIX_WIDTH'(SCORE_Y0);
    localparam logic [PIX_WIDTH-1:0] SCORE_Y_HI = PIX_WIDTH'(SCORE_Y0 + CHAR_PX);
    localparam logic [PIX_WIDTH-1:0] LINES_Y_LO = PIX_WIDTH'(LINES_Y0);
    localparam logic [PIX_WIDTH-1:0] LINES_Y_HI = PIX_WIDTH'(LINES_Y0 + CHAR_PX);
    localparam logic [PIX_WIDTH-1:0] LEVEL_Y_LO = PIX_WIDTH'(LEVEL_Y0);
    localparam logic [PIX_WIDTH-1:0] LEVEL_Y_HI = PIX_WIDTH'(LEVEL_Y0 + CHAR_PX);
    localparam logic [PIX_WIDTH-1:0] GO_X_LO    = PIX_WIDTH'(GO_X0);
    localparam logic [PIX_WIDTH-1:0] GO_X_HI    = PIX_WIDTH'(GO_X0 + 9 * CHAR_PX);
    localparam logic [PIX_WIDTH-1:0] GO_Y_LO    = PIX_WIDTH'(GO_Y0);
    localparam logic [PIX_WIDTH-1:0] GO_Y_HI    = PIX_WIDTH'(GO_Y0 + CHAR_PX);

`ifdef DRAW_STRINGS_GO_BLINK_EN
    localparam logic BLINK_EN = 1'b1;
`else
    localparam logic BLINK_EN = 1'b0;
`endif

    // Digits take codes 0-9 so a BCD nibble casts straight to its glyph.
    typedef enum logic [4:0] {
        CH_0, CH_1, CH_2, CH_3, CH_4, CH_5, CH_6, CH_7, CH_8, CH_9,
        CH_A, CH_C, CH_E, CH_G, CH_I, CH_L, CH_M, CH_N, CH_O, CH_R,
        CH_S, CH_V, CH_SP
    } char_t;

    typedef enum logic [2:0] {
        SEL_NONE, SEL_GO, SEL_SCORE, SEL_LINES, SEL_LEVEL
    } sel_t;

    // -------------------------------------------------------------------------
    // Font ROM: 8 rows per glyph, top row in the top byte, bit 7 = leftmost.
    // NOTE: the font is pure combinational constant logic, so there is no
    // storage here to reset.
    // -------------------------------------------------------------------------
    function automatic logic [7:0] glyph_bits(input char_t c, input logic [2:0] row);
        logic [63:0] g;
        case (c)
            CH_0:    g = 64'h3C666E7666663C00;
            CH_1:    g = 64'h1838181818187E00;
            CH_2:    g = 64'h3C66060C30607E00;
            CH_3:    g = 64'h3C66061C06663C00;
            CH_4:    g = 64'h0C1C3C6C7E0C0C00;
            CH_5:    g = 64'h7E607C0606663C00;
            CH_6:    g = 64'h3C607C6666663C00;
            CH_7:    g = 64'h7E060C1830303000;
            CH_8:    g = 64'h3C66663C66663C00;
            CH_9:    g = 64'h3C66663E060C3800;
            CH_A:    g = 64'h183C66667E666600;
            CH_C:    g = 64'h3C66606060663C00;
            CH_E:    g = 64'h7E60607C60607E00;
            CH_G:    g = 64'h3C66606E66663C00;
            CH_I:    g = 64'h3C18181818183C00;
            CH_L:    g = 64'h6060606060607E00;
            CH_M:    g = 64'h63777F6B63636300;
            CH_N:    g = 64'h66767E7E6E666600;
            CH_O:    g = 64'h3C66666666663C00;
            CH_R:    g = 64'h7C66667C786C6600;
            CH_S:    g = 64'h3C66603C06663C00;
            CH_V:    g = 64'h66666666663C1800;
            default: g = 64'h0;
        endcase
        // Row r occupies bits [63-8r -: 8]; {~r,3'b111} == 63-8r.
        return g[{~row, 3'b111} -: 8];
    endfunction

    function automatic char_t label_char(input sel_t s, input logic [3:0] idx);
        char_t c;
        c = CH_SP;
        case (s)
            SEL_SCORE: case (idx)
                4'd0: c = CH_S;  4'd1: c = CH_C;  4'd2: c = CH_O;
                4'd3: c = CH_R;  4'd4: c = CH_E;  default: c = CH_SP;
            endcase
            SEL_LINES: case (idx)
                4'd0: c = CH_L;  4'd1: c = CH_I;  4'd2: c = CH_N;
                4'd3: c = CH_E;  4'd4: c = CH_S;  default: c = CH_SP;
            endcase
            SEL_LEVEL: case (idx)
                4'd0: c = CH_L;  4'd1: c = CH_E;  4'd2: c = CH_V;
                4'd3: c = CH_E;  4'd4: c = CH_L;  default: c = CH_SP;
            endcase
            default: c = CH_SP;
        endcase
        return c;
    endfunction

    function automatic char_t banner_char(input logic [3:0] idx);
        char_t c;
        case (idx)
            4'd0: c = CH_G;  4'd1: c = CH_A;  4'd2: c = CH_M;
            4'd3: c = CH_E;  4'd5: c = CH_O;  4'd6: c = CH_V;
            4'd7: c = CH_E;  4'd8: c = CH_R;  default: c = CH_SP;
        endcase
        return c;
    endfunction

    // Character positions 6..11 carry the BCD digits, most significant first.
    // Nibbles 10-15 are not valid BCD and draw as blank.
    function automatic char_t digit_char(input logic [23:0] bcd, input logic [3:0] idx);
        logic [3:0] nib;
        case (idx)
            4'd6:    nib = bcd[23:20];
            4'd7:    nib = bcd[19:16];
            4'd8:    nib = bcd[15:12];
            4'd9:    nib = bcd[11:8];
            4'd10:   nib = bcd[7:4];
            default: nib = bcd[3:0];
        endcase
        return (nib < 4'd10) ? char_t'({1'b0, nib}) : CH_SP;
    endfunction

    // -------------------------------------------------------------------------
    // Frame tracking and statistics snapshot
    // -------------------------------------------------------------------------
    logic [PIX_WIDTH-1:0] prev_y;
    logic [23:0]          sh_score, sh_lines, sh_level;
    logic                 sh_game_over;
    logic [7:0]           frame_cnt;
    logic                 frame_start;

    assign frame_start = (pix_y_i == '0) && (prev_y != '0);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_y       <= '0;
            sh_score     <= '0;
            sh_lines     <= '0;
            sh_level     <= '0;
            sh_game_over <= 1'b0;
            frame_cnt    <= '0;
        end else begin
            prev_y <= pix_y_i;
            if (frame_start) begin
                sh_score     <= gd_score;
                sh_lines     <= gd_lines;
                sh_level     <= gd_level;
                sh_game_over <= gd_game_over_state;
                frame_cnt    <= frame_cnt + 8'd1;
            end
        end
    end

    logic go_visible;
    assign go_visible = sh_game_over && (!BLINK_EN || !frame_cnt[BLINK_BIT]);

    // -------------------------------------------------------------------------
    // Hit test and glyph lookup
    // -------------------------------------------------------------------------
    sel_t                 sel;
    logic [PIX_WIDTH-1:0] org_x, org_y, rel_x, rel_y;
    logic [3:0]           char_idx;
    logic [2:0]           glyph_col, glyph_row;
    char_t                ch;
    logic [7:0]           row_bits;
    logic [23:0]          color;
    logic                 in_stat_x, pix_on;

    // NOTE: every variable gets a default at the top of the block so no path
    // leaves one unassigned, which would infer a latch.
    always_comb begin
        sel   = SEL_NONE;
        org_x = '0;
        org_y = '0;
        ch    = CH_SP;
        color = TEXT_COLOR;

        in_stat_x = (pix_x_i >= STAT_X_LO) && (pix_x_i < STAT_X_HI);

        // Banner is tested first so it wins wherever it overlaps a stat line.
        if (go_visible && pix_x_i >= GO_X_LO && pix_x_i < GO_X_HI &&
            pix_y_i >= GO_Y_LO && pix_y_i < GO_Y_HI) begin
            sel = SEL_GO;    org_x = GO_X_LO;   org_y = GO_Y_LO;
        end else if (in_stat_x && pix_y_i >= SCORE_Y_LO && pix_y_i < SCORE_Y_HI) begin
            sel = SEL_SCORE; org_x = STAT_X_LO; org_y = SCORE_Y_LO;
        end else if (in_stat_x && pix_y_i >= LINES_Y_LO && pix_y_i < LINES_Y_HI) begin
            sel = SEL_LINES; org_x = STAT_X_LO; org_y = LINES_Y_LO;
        end else if (in_stat_x && pix_y_i >= LEVEL_Y_LO && pix_y_i < LEVEL_Y_HI) begin
            sel = SEL_LEVEL; org_x = STAT_X_LO; org_y = LEVEL_Y_LO;
        end

        // Origin is zero when nothing is hit, so the subtraction never wraps.
        rel_x     = pix_x_i - org_x;
        rel_y     = pix_y_i - org_y;
        char_idx  = 4'(rel_x >> (3 + SCALE_LOG2));
        glyph_col = 3'(rel_x >> SCALE_LOG2);
        glyph_row = 3'(rel_y >> SCALE_LOG2);

        case (sel)
            SEL_GO: begin
                ch    = banner_char(char_idx);
                color = GO_COLOR;
            end
            SEL_SCORE: ch = (char_idx < 4'd6) ? label_char(sel, char_idx) : digit_char(sh_score, char_idx);
            SEL_LINES: ch = (char_idx < 4'd6) ? label_char(sel, char_idx) : digit_char(sh_lines, char_idx);
            SEL_LEVEL: ch = (char_idx < 4'd6) ? label_char(sel, char_idx) : digit_char(sh_level, char_idx);
            default:   ch = CH_SP;
        endcase

        row_bits = glyph_bits(ch, glyph_row);
        pix_on   = (sel != SEL_NONE) && row_bits[~glyph_col];
    end

    // -------------------------------------------------------------------------
    // Output register (single pipeline stage)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vga_data_o    <= '0;
            vga_data_en_o <= 1'b0;
        end else begin
            vga_data_o    <= pix_on ? color : 24'h0;
            vga_data_en_o <= pix_on;
        end
    end

endmodule

// File: tb/tb_draw_strings.sv
// -----------------------------------------------------------------------------
// tb_draw_strings
//   Self-checking bench for draw_strings. Each driven pixel pushes its expected
//   {en, data} into a scoreboard queue; one clock later the entry is popped and
//   compared with the registered DUT output. Expected glyph rows are literal
//   font constants ('7' row0 = 7E, '0' row0 = 3C / row1 = 66, 'S','L','G','O'
//   row0 lit at column 2).
// -----------------------------------------------------------------------------
module tb_draw_strings;

    localparam logic [23:0] WHITE = 24'hFFFFFF;
    localparam logic [23:0] RED   = 24'hFF0000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [11:0] pix_x, pix_y;
    logic [23:0] gd_score, gd_lines, gd_level;
    logic        gd_game_over_state;
    logic [23:0] vga_data_o;
    logic        vga_data_en_o;

    typedef struct packed {
        logic        en;
        logic [23:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   frames   = 0;   // frame starts since last reset release

    draw_strings dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .pix_x_i            (pix_x),
        .pix_y_i            (pix_y),
        .gd_score           (gd_score),
        .gd_lines           (gd_lines),
        .gd_level           (gd_level),
        .gd_game_over_state (gd_game_over_state),
        .vga_data_o         (vga_data_o),
        .vga_data_en_o      (vga_data_en_o)
    );

    always #5 clk = ~clk;

    // Present a pixel and advance to 1 time unit after the edge that registers it.
    task automatic drive(input int x, input int y);
        pix_x = 12'(x);
        pix_y = 12'(y);
        @(posedge clk);
        #1;
    endtask

    // pix_y 1023 -> 0 produces one frame-start event.
    task automatic frame_start();
        drive(0, 1023);
        drive(0, 0);
        frames++;
    endtask

    task automatic test_reset();
        int   xs[6]  = '{1156, 504, 808, 0, 1156, 1156};
        int   ys[6]  = '{200, 480, 200, 0, 204, 200};
        logic ens[6] = '{0, 0, 0, 0, 1, 0};
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) begin
                // Release mid-frame: snapshot is still zero, digits read "000000".
                pix_y   = 12'd100;
                reset_n = 1'b1;
                frames  = 0;
            end
            exp_q.push_back('{en: ens[i], data: ens[i] ? WHITE : 24'h0});
            drive(xs[i], ys[i]);
            e = exp_q.pop_front();
            n_checks++;
            if (vga_data_en_o !== e.en || vga_data_o !== e.data) begin
                n_fail++;
                $display("FAIL reset[%0d] (%0d,%0d): got en=%b data=%h, want en=%b data=%h",
                         i, xs[i], ys[i], vga_data_en_o, vga_data_o, e.en, e.data);
            end
        end
    endtask

    task automatic test_score_digit();
        int   ys[4]  = '{200, 204, 200, 204};
        logic ens[4] = '{1, 0, 0, 1};
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) frame_start();           // snapshots score = 000007
            if (i == 2) begin
                gd_score = 24'h000000;
                frame_start();
            end
            exp_q.push_back('{en: ens[i], data: ens[i] ? WHITE : 24'h0});
            drive(1156, ys[i]);
            e = exp_q.pop_front();
            n_checks++;
            if (vga_data_en_o !== e.en || vga_data_o !== e.data) begin
                n_fail++;
                $display("FAIL score_digit[%0d] (1156,%0d): got en=%b data=%h, want en=%b data=%h",
                         i, ys[i], vga_data_en_o, vga_data_o, e.en, e.data);
            end
        end
    endtask

    task automatic test_snapshot();
        logic ens[3] = '{0, 0, 1};
        exp_t e;
        gd_score = 24'h000007;                   // mid-frame change, shadow holds 0
        for (int i = 0; i < 3; i++) begin
            if (i == 2) frame_start();
            exp_q.push_back('{en: ens[i], data: ens[i] ? WHITE : 24'h0});
            drive(1156, 200 + i * 0);
            e = exp_q.pop_front();
            n_checks++;
            if (vga_data_en_o !== e.en || vga_data_o !== e.data) begin
                n_fail++;
                $display("FAIL snapshot[%0d]: got en=%b data=%h, want en=%b data=%h",
                         i, vga_data_en_o, vga_data_o, e.en, e.data);
            end
        end
    endtask

    task automatic test_boundary();
        int   xs[8]  = '{799, 1184, 808, 1183, 1156, 1156, 808, 808};
        int   ys[8]  = '{200, 200, 200, 200, 199, 232, 264, 328};
        logic ens[8] = '{0, 0, 1, 0, 0, 0, 1, 1};
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back('{en: ens[i], data: ens[i] ? WHITE : 24'h0});
            drive(xs[i], ys[i]);
            e = exp_q.pop_front();
            n_checks++;
            if (vga_data_en_o !== e.en || vga_data_o !== e.data) begin
                n_fail++;
                $display("FAIL boundary[%0d] (%0d,%0d): got en=%b data=%h, want en=%b data=%h",
                         i, xs[i], ys[i], vga_data_en_o, vga_data_o, e.en, e.data);
            end
        end
    endtask

    // Sweep every x of the last SCORE digit ('7', row 0) on consecutive cycles.
    task automatic test_back_to_back();
        logic [7:0] row7 = 8'h7E;
        logic       bit_on;
        exp_t       e;
        for (int x = 1152; x < 1184; x++) begin
            bit_on = row7[7 - ((x - 1152) >> 2)];
            exp_q.push_back('{en: bit_on, data: bit_on ? WHITE : 24'h0});
            drive(x, 200);
            e = exp_q.pop_front();
            n_checks++;
            if (vga_data_en_o !== e.en || vga_data_o !== e.data) begin
                n_fail++;
                $display("FAIL back_to_back x=%0d: got en=%b data=%h, want en=%b data=%h",
                         x, vga_data_en_o, vga_data_o, e.en, e.data);
            end
        end
    endtask

    task automatic test_game_over();
        int   xs[4]  = '{504, 495, 664, 504};
        logic ens[4] = '{1, 0, 1, 0};
        exp_t e;
        gd_game_over_state = 1'b1;
        frame_start();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                gd_game_over_state = 1'b0;
                frame_start();
            end
            exp_q.push_back('{en: ens[i], data: ens[i] ? RED : 24'h0});
            drive(xs[i], 480);
            e = exp_q.pop_front();
            n_checks++;
            if (vga_data_en_o !== e.en || vga_data_o !== e.data) begin
                n_fail++;
                $display("FAIL game_over[%0d] (%0d,480): got en=%b data=%h, want en=%b data=%h",
                         i, xs[i], vga_data_en_o, vga_data_o, e.en, e.data);
            end
        end
    endtask

    // Crosses frame counts 32, 64 ... and the 256 wrap.
    task automatic test_blink();
        logic vis;
        exp_t e;
        gd_game_over_state = 1'b1;
        for (int i = 0; i < 300; i++) begin
            frame_start();
`ifdef DRAW_STRINGS_GO_BLINK_EN
            vis = (((frames % 256) >> 5) & 1) == 0;
`else
            vis = 1'b1;
`endif
            exp_q.push_back('{en: vis, data: vis ? RED : 24'h0});
            drive(504, 480);
            e = exp_q.pop_front();
            n_checks++;
            if (vga_data_en_o !== e.en || vga_data_o !== e.data) begin
                n_fail++;
                $display("FAIL blink frame=%0d: got en=%b data=%h, want en=%b data=%h",
                         frames, vga_data_en_o, vga_data_o, e.en, e.data);
            end
        end
    endtask

    initial begin
        reset_n            = 1'b0;
        pix_x              = '0;
        pix_y              = '0;
        gd_score           = 24'h000007;
        gd_lines           = 24'h000000;
        gd_level           = 24'h000001;
        gd_game_over_state = 1'b0;
        #1;
        test_reset();
        test_score_digit();
        test_snapshot();
        test_boundary();
        test_back_to_back();
        test_game_over();
        test_blink();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
